// File: rtl/spi_frame_pwm.sv
// spi_frame_pwm
//   Framed SPI receiver feeding NUM_CH double-buffered PWM channels.
//   Frame format: SYNC_BYTE, NUM_CH duty bytes, additive (mod 256) checksum
//   of the duty bytes. A good frame is staged in the pending bank and moves
//   to the active bank only at a PWM period boundary, so a period is never
//   cut short or stretched by a new duty value.
//
// Ports
//   clk12     in   system clock
//   reset     in   asynchronous active-high reset
//   sck0      in   SPI clock (asynchronous to clk12)
//   mosi      in   SPI data, MSB first
//   cs        in   SPI chip select, active low
//   pwm_out   out  [NUM_CH] registered PWM outputs, bit i = channel i
//   frame_ok  out  one-cycle pulse, valid frame committed to pending
//   frame_err out  one-cycle pulse, checksum mismatch or inter-byte timeout
//   busy      out  frame FSM is not in HUNT
//
// Frame FSM
//   state  | meaning
//   HUNT   | waiting for SYNC_BYTE, all other bytes dropped
//   DATA   | collecting duty byte idx into shadow, accumulating sum
//   CSUM   | next byte is the checksum; commit or flag error, back to HUNT

module spi_frame_pwm #(
   parameter int           NUM_CH         = 4,
   parameter int           SPI_MODE       = 1,
   parameter logic [7:0]   SYNC_BYTE      = 8'h55,
   parameter int           PWM_BITS       = 8,
   parameter int           TIMEOUT_CYCLES = 4096
) (
   input  logic              clk12,
   input  logic              reset,
   input  logic              sck0,
   input  logic              mosi,
   input  logic              cs,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_ok,
   output logic              frame_err,
   output logic              busy
);

   localparam logic CPOL        = (SPI_MODE == 2) || (SPI_MODE == 3);
   localparam logic SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);
   localparam int   IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int   TMR_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_HUNT,
      S_DATA,
      S_CSUM
   } state_t;

   // ---------------------------------------------------------------
   // Input synchronisers. sck gets a third stage for edge detection.
   // Reset values match the idle bus so release never fakes an edge
   // or a selected chip.
   // ---------------------------------------------------------------
   logic [2:0] sck_sr;
   logic [1:0] mosi_sr;
   logic [1:0] cs_sr;

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         sck_sr  <= {3{CPOL}};
         mosi_sr <= 2'b00;
         cs_sr   <= 2'b11;
      end else begin
         sck_sr  <= {sck_sr[1:0], sck0};
         mosi_sr <= {mosi_sr[0], mosi};
         cs_sr   <= {cs_sr[0], cs};
      end
   end

   logic sck_rise, sck_fall, sample_edge, mosi_s, cs_s;

   assign sck_rise    = sck_sr[1] & ~sck_sr[2];
   assign sck_fall    = ~sck_sr[1] & sck_sr[2];
   assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
   assign mosi_s      = mosi_sr[1];
   assign cs_s        = cs_sr[1];

   // ---------------------------------------------------------------
   // Byte assembler. cs high drops any partial byte.
   // ---------------------------------------------------------------
   logic [2:0] bit_cnt;
   logic [7:0] shift_q;
   logic       byte_done;

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         bit_cnt   <= 3'd0;
         shift_q   <= 8'h00;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (cs_s) begin
            bit_cnt <= 3'd0;
         end else if (sample_edge) begin
            shift_q <= {shift_q[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_done <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [TMR_W-1:0] tmr_q;
   logic             tmo;
   logic             shadow_we;
   logic             commit;
   logic             ok_d, err_d;

   // Down-counter reloaded by every byte; expiry only matters outside HUNT.
   assign tmo = (tmr_q == '0);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      shadow_we = 1'b0;
      commit    = 1'b0;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         S_HUNT: begin
            if (byte_done && (shift_q == SYNC_BYTE)) begin
               state_d = S_DATA;
               idx_d   = '0;
               sum_d   = 8'h00;
            end
         end
         S_DATA: begin
            if (byte_done) begin
               shadow_we = 1'b1;
               sum_d     = sum_q + shift_q;
               if (idx_q == IDX_LAST) begin
                  state_d = S_CSUM;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (tmo) begin
               state_d = S_HUNT;
               err_d   = 1'b1;
            end
         end
         S_CSUM: begin
            if (byte_done) begin
               state_d = S_HUNT;
               if (shift_q == sum_q) begin
                  commit = 1'b1;
                  ok_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (tmo) begin
               state_d = S_HUNT;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_HUNT;
         end
      endcase
   end

   logic [7:0] shadow_q [NUM_CH];

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         state_q   <= S_HUNT;
         idx_q     <= '0;
         sum_q     <= 8'h00;
         tmr_q     <= TMR_LOAD;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= 8'h00;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         frame_ok  <= ok_d;
         frame_err <= err_d;
         if (byte_done || (state_q == S_HUNT)) begin
            tmr_q <= TMR_LOAD;
         end else if (!tmo) begin
            tmr_q <= tmr_q - 1'b1;
         end
         if (shadow_we) begin
            shadow_q[idx_q] <= shift_q;
         end
      end
   end

   assign busy = (state_q != S_HUNT);

   // ---------------------------------------------------------------
   // Duty banks and PWM
   // ---------------------------------------------------------------
   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] pending_q [NUM_CH];
   logic [PWM_BITS-1:0] active_q  [NUM_CH];
   logic                pend_valid_q;
   logic                wrap;

   // wrap marks the last count of a period; active switches on this edge
   // so the very first count of the next period already uses new duties.
   assign wrap = (cnt_q == '1);

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pwm_out      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pending_q[i] <= '0;
            active_q[i]  <= '0;
         end
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (wrap && pend_valid_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
               active_q[i] <= pending_q[i];
            end
         end
         // A commit on the wrap cycle stays pending for the following wrap.
         if (commit) begin
            for (int i = 0; i < NUM_CH; i++) begin
               pending_q[i] <= PWM_BITS'(shadow_q[i]);
            end
            pend_valid_q <= 1'b1;
         end else if (wrap) begin
            pend_valid_q <= 1'b0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            pwm_out[i] <= (cnt_q < active_q[i]);
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_pwm.sv
`timescale 1ns/1ps

module tb_spi_frame_pwm;

   localparam int TMO = 4096;
   localparam int H   = 40;

   logic       clk12 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] sck_v = 4'b1100;
   logic [3:0] cs_v  = 4'b1111;
   logic       mosi  = 1'b0;

   logic [3:0] pwm_v [4];
   logic [3:0] ok_v, err_v, busy_v;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int dut;
      int kind;
   } ev_t;

   ev_t exp_q [$];

   always #5 clk12 = ~clk12;

   // one DUT per SPI mode; DUT index == SPI_MODE
   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_frame_pwm #(
         .NUM_CH(4), .SPI_MODE(g), .SYNC_BYTE(8'h55), .PWM_BITS(8), .TIMEOUT_CYCLES(TMO)
      ) dut (
         .clk12    (clk12),
         .reset    (reset),
         .sck0     (sck_v[g]),
         .mosi     (mosi),
         .cs       (cs_v[g]),
         .pwm_out  (pwm_v[g]),
         .frame_ok (ok_v[g]),
         .frame_err(err_v[g]),
         .busy     (busy_v[g])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int d, input int kind);
      ev_t e;
      e.dut  = d;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   // monitor: every frame_ok/frame_err pulse must match the queue head
   initial begin
      ev_t e;
      int  kind;
      forever begin
         @(negedge clk12);
         if (!reset) begin
            for (int d = 0; d < 4; d++) begin
               if (ok_v[d] || err_v[d]) begin
                  total++;
                  if (ok_v[d] && err_v[d]) begin
                     bad++;
                     $display("FAIL pulse_overlap: dut=%0d ok=1 err=1 required one of them", d);
                  end
                  kind = ok_v[d] ? 1 : 2;
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_event: dut=%0d kind=%0d required none", d, kind);
                  end else begin
                     e = exp_q.pop_front();
                     if (e.dut != d || e.kind != kind) begin
                        bad++;
                        $display("FAIL event: dut=%0d kind=%0d required dut=%0d kind=%0d",
                                 d, kind, e.dut, e.kind);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #400us;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic spi_bits(input int d, input logic [7:0] b, input int nbits);
      logic [1:0] m;
      logic       cpol, cpha;
      m    = 2'(d);
      cpol = m[1];
      cpha = m[0];
      cs_v[d] = 1'b0;
      #(H);
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi = b[i];
            #(H);
            sck_v[d] = ~cpol;
            #(H);
            sck_v[d] = cpol;
         end else begin
            sck_v[d] = ~cpol;
            mosi     = b[i];
            #(H);
            sck_v[d] = cpol;
            #(H);
         end
      end
      #(H);
      cs_v[d] = 1'b1;
      #(2*H);
   endtask

   task automatic spi_byte(input int d, input logic [7:0] b);
      spi_bits(d, b, 8);
   endtask

   task automatic send_frame(input int d, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4, input logic [7:0] b5);
      spi_byte(d, b0);
      spi_byte(d, b1);
      spi_byte(d, b2);
      spi_byte(d, b3);
      spi_byte(d, b4);
      spi_byte(d, b5);
   endtask

   // waits past commit and one full period, then counts high cycles per channel
   task automatic check_duties(input int d, input string tag,
                               input int e0, input int e1, input int e2, input int e3);
      int cnt [4];
      int ex  [4];
      ex = '{e0, e1, e2, e3};
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      repeat (600) @(negedge clk12);
      repeat (256) begin
         @(negedge clk12);
         for (int c = 0; c < 4; c++) if (pwm_v[d][c]) cnt[c]++;
      end
      for (int c = 0; c < 4; c++) chk($sformatf("%s_d%0d_ch%0d", tag, d, c), cnt[c], ex[c]);
   endtask

   initial begin
      bit found;

      // reset state
      repeat (5) @(negedge clk12);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_pwm_d%0d", d), int'(pwm_v[d]), 0);
         chk($sformatf("rst_busy_d%0d", d), int'(busy_v[d]), 0);
         chk($sformatf("rst_pulses_d%0d", d), int'({ok_v[d], err_v[d]}), 0);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk12);
      check_duties(1, "idle", 0, 0, 0, 0);

      // basic frame, mode 1
      expect_ev(1, 1);
      send_frame(1, 8'h55, 8'hFF, 8'h24, 8'h00, 8'h80, 8'hA3);
      check_duties(1, "basic", 255, 36, 0, 128);

      // bad checksum keeps previous duties
      expect_ev(1, 2);
      send_frame(1, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00);
      check_duties(1, "badsum", 255, 36, 0, 128);
      chk("badsum_drained", exp_q.size(), 0);

      // garbage before sync
      spi_byte(1, 8'h00);
      chk("garb0_busy", int'(busy_v[1]), 0);
      spi_byte(1, 8'hAA);
      chk("garb1_busy", int'(busy_v[1]), 0);
      spi_byte(1, 8'h3C);
      chk("garb2_busy", int'(busy_v[1]), 0);
      spi_byte(1, 8'h55);
      chk("sync_busy", int'(busy_v[1]), 1);
      expect_ev(1, 1);
      spi_byte(1, 8'h01);
      spi_byte(1, 8'h02);
      spi_byte(1, 8'h03);
      spi_byte(1, 8'h04);
      spi_byte(1, 8'h0A);
      check_duties(1, "resync", 1, 2, 3, 4);

      // timeout
      expect_ev(1, 2);
      spi_byte(1, 8'h55);
      spi_byte(1, 8'h10);
      chk("tmo_busy_before", int'(busy_v[1]), 1);
      repeat (TMO + 10) @(negedge clk12);
      chk("tmo_busy_after", int'(busy_v[1]), 0);
      chk("tmo_err_seen", exp_q.size(), 0);
      expect_ev(1, 1);
      send_frame(1, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
      check_duties(1, "after_tmo", 17, 34, 51, 68);

      // cs abort mid-byte, every SPI mode
      for (int d = 0; d < 4; d++) begin
         spi_bits(d, 8'hA5, 4);
         expect_ev(d, 1);
         send_frame(d, 8'h55, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
         check_duties(d, "csabort", 5, 6, 7, 8);
      end

      // reset in DATA and during PWM high time
      spi_byte(1, 8'h55);
      spi_byte(1, 8'h99);
      spi_byte(1, 8'h77);
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk12);
         if (pwm_v[1][0]) found = 1'b1;
      end
      chk("pre_rst_pwm_high", int'(found), 1);
      chk("pre_rst_busy", int'(busy_v[1]), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_pwm", int'(pwm_v[1]), 0);
      chk("async_rst_busy", int'(busy_v[1]), 0);
      chk("async_rst_pulses", int'({ok_v[1], err_v[1]}), 0);
      repeat (3) @(negedge clk12);
      reset = 1'b0;
      spi_byte(1, 8'h66);
      spi_byte(1, 8'h5D);
      check_duties(1, "post_rst", 0, 0, 0, 0);
      expect_ev(1, 1);
      send_frame(1, 8'h55, 8'hFF, 8'h24, 8'h00, 8'h80, 8'hA3);
      check_duties(1, "post_rst_frame", 255, 36, 0, 128);

      repeat (50) @(negedge clk12);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
